register_file_wb: RTL and testbench
===================================

REGISTER_FILE_WB -- requirements
Module: register_file_wb

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning register and data width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 5, meaning register address width, giving 2**ADDR_W registers.

Ports:
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have port rs_addr, input, ADDR_W bits: read port A address.
REQ-006 The block SHALL have port rt_addr, input, ADDR_W bits: read port B address.
REQ-007 The block SHALL have port rs_data, output, DATA_W bits: read port A data.
REQ-008 The block SHALL have port rt_data, output, DATA_W bits: read port B data.
REQ-009 The block SHALL have port wr_en, input, 1 bit: write-back enable.
REQ-010 The block SHALL have port wr_addr, input, ADDR_W bits: write-back destination register.
REQ-011 The block SHALL have port wr_data, input, DATA_W bits: write-back value, driven by the 3:1 write-back source select (ALU result / memory data / PC+4).
REQ-012 The block SHALL have port dump_start, input, 1 bit: request a debug dump of all registers.
REQ-013 The block SHALL have port dump_busy, output, 1 bit: a dump is in progress.
REQ-014 The block SHALL have port dump_valid, output, 1 bit: dump_idx and dump_data are valid this cycle.
REQ-015 The block SHALL have port dump_idx, output, ADDR_W bits: index of the register being dumped.
REQ-016 The block SHALL have port dump_data, output, DATA_W bits: contents of register dump_idx.

Function
REQ-017 The block SHALL hold 2**ADDR_W registers; register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-018 Reads SHALL be combinational: rs_data = reg[rs_addr] and rt_data = reg[rt_addr] in the same cycle.
REQ-019 When wr_en=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data at the rising clk edge.
REQ-020 Bypass: when wr_en=1, wr_addr!=0 and wr_addr equals a read address, that read port SHALL output wr_data combinationally in the same cycle.
REQ-021 The dump FSM SHALL have states IDLE and DUMP.
REQ-022 IDLE->DUMP SHALL occur on a clk edge with dump_start=1; the index counter SHALL load 0.
REQ-023 In DUMP, dump_valid=1 and dump_busy=1 every cycle; dump_idx SHALL increment by 1 per cycle.
REQ-024 dump_data SHALL equal reg[dump_idx], including the REQ-020 bypass when a same-cycle write hits dump_idx.
REQ-025 After the cycle with dump_idx = 2**ADDR_W-1, the FSM SHALL return to IDLE; a dump therefore lasts exactly 2**ADDR_W cycles.
REQ-026 dump_start while in DUMP SHALL be ignored; the current dump is neither restarted nor extended.
REQ-027 Write-back SHALL proceed normally during a dump; the dump never stalls or blocks writes.
REQ-028 In IDLE: dump_valid=0, dump_busy=0, dump_idx=0, dump_data=0.

Reset
REQ-029 Asserting rst SHALL immediately, independent of clk, clear all registers to 0 and force the FSM to IDLE with dump outputs per REQ-028, including mid-dump.
REQ-030 While rst=1, writes and dump_start SHALL be ignored.
REQ-031 After rst deasserts, the first clk edge SHALL accept writes and dump_start normally.

Verification
REQ-032 Reset, then write 0x0000000E to r5 and 0x00000018 to r31; set rs_addr=5, rt_addr=31 -> rs_data=0x0000000E, rt_data=0x00000018.
REQ-033 Write 0xDEADBEEF to r0, then read r0 on both ports -> both read 0x00000000.
REQ-034 Set wr_en=1, wr_addr=7, wr_data=0x00000003, rs_addr=7 in the same cycle -> rs_data=0x00000003 before the edge.
REQ-035 Pulse dump_start with r5=0x0E loaded -> dump_valid high for exactly 32 cycles; dump_idx runs 0..31; dump_data=0x0E at idx 5; dump_busy falls afterwards.
REQ-036 Assert rst asynchronously at dump_idx=10 -> dump_valid=0 and dump_idx=0 immediately, and all reads return 0.
REQ-037 Re-pulse dump_start at idx 4, and write 0x55 to r20 during the dump -> dump still ends after idx 31; idx 20 shows 0x55.

Source files
------------

// File: rtl/register_file_wb.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_wb
//  Description : 2**ADDR_W x DATA_W register file with two combinational read
//                ports, one write-back port with same-cycle write bypass, and
//                a sequential debug dump engine that streams every register.
//  Revision    : 1.0 - initial release
// ============================================================================
module register_file_wb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              dump_start,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data
);

  localparam int c_NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DUMP = 1'b1
  } state_t;

  logic [DATA_W-1:0] regs_q [c_NUM_REGS];
  logic [DATA_W-1:0] regs_d [c_NUM_REGS];
  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [ADDR_W-1:0] idx_d;
  logic              wr_hit;

  // A write is live only outside reset and never to the hard-wired zero register.
  assign wr_hit = wr_en && (wr_addr != '0) && !rst;

  // Reads see the stored value, with the in-flight write forwarded on address match.
  function automatic logic [DATA_W-1:0] read_reg(
    input logic [ADDR_W-1:0] addr,
    input logic              hit,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    logic [DATA_W-1:0] val;
    val = stored;
    if (addr == '0) begin
      val = '0;
    end else if (hit && (waddr == addr)) begin
      val = wdata;
    end
    return val;
  endfunction

  // Next register-array contents: only the addressed entry changes on a write.
  always_comb begin
    for (int i = 0; i < c_NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (wr_hit) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Register array storage with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Both read ports, combinational with write bypass.
  always_comb begin
    rs_data = read_reg(rs_addr, wr_hit, wr_addr, wr_data, regs_q[rs_addr]);
    rt_data = read_reg(rt_addr, wr_hit, wr_addr, wr_data, regs_q[rt_addr]);
  end

  // Dump FSM next state: a start request only matters when idle, and a dump
  // always runs the full index range exactly once.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dump_busy  = 1'b0;
    dump_valid = 1'b0;
    dump_idx   = '0;
    dump_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          state_d = ST_DUMP;
          idx_d   = '0;
        end
      end
      ST_DUMP: begin
        dump_busy  = 1'b1;
        dump_valid = 1'b1;
        dump_idx   = idx_q;
        dump_data  = read_reg(idx_q, wr_hit, wr_addr, wr_data, regs_q[idx_q]);
        if (idx_q == {ADDR_W{1'b1}}) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Dump FSM state and index registers with asynchronous return to idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_register_file_wb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_register_file_wb
//  Description : Directed self-checking bench for register_file_wb with a
//                behavioural reference model checked every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_register_file_wb;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs_addr, rt_addr, wr_addr;
  logic [DW-1:0] rs_data, rt_data, wr_data, dump_data;
  logic          wr_en, dump_start, dump_busy, dump_valid;
  logic [AW-1:0] dump_idx;

  int vectors = 0;
  int miscompares = 0;
  bit done = 1'b0;

  register_file_wb #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs_addr    (rs_addr),
    .rt_addr    (rt_addr),
    .rs_data    (rs_data),
    .rt_data    (rt_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dump_start (dump_start),
    .dump_busy  (dump_busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int unsigned model_reg [NREG];
  int          dump_left = 0;   // dump cycles still to be shown, 0 = idle

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int a);
    if (a == 0) return '0;
    if (!rst && wr_en && (int'(wr_addr) == a)) return wr_data;
    return model_reg[a];
  endfunction

  always @(posedge rst) begin
    for (int i = 0; i < NREG; i++) model_reg[i] = 0;
    dump_left = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      if (wr_en && wr_addr != 0) model_reg[wr_addr] = wr_data;
      if (dump_left > 0) dump_left = dump_left - 1;
      else if (dump_start) dump_left = NREG;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (!done) begin
      int ei;
      logic eb;
      eb = (dump_left > 0);
      ei = eb ? (NREG - dump_left) : 0;
      chk("m_rs_data",    rs_data,   exp_read(int'(rs_addr)));
      chk("m_rt_data",    rt_data,   exp_read(int'(rt_addr)));
      chk("m_dump_busy",  {31'd0, dump_busy},  {31'd0, eb});
      chk("m_dump_valid", {31'd0, dump_valid}, {31'd0, eb});
      chk("m_dump_idx",   {27'd0, dump_idx},   DW'(ei));
      chk("m_dump_data",  dump_data, eb ? exp_read(ei) : '0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int a, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    bit found;
    rst = 1'b1; rs_addr = '0; rt_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; dump_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    rs_addr = 5; rt_addr = 31;
    @(negedge clk);
    chk("reset_rs", rs_data, 32'h0);
    chk("reset_busy", {31'd0, dump_busy}, 32'h0);
    chk("reset_idx", {27'd0, dump_idx}, 32'h0);

    // Basic write then read on both ports.
    tick();
    do_write(5, 32'h0000000E);
    do_write(31, 32'h00000018);
    @(negedge clk);
    chk("rd_r5", rs_data, 32'h0000000E);
    chk("rd_r31", rt_data, 32'h00000018);
    chk("model_r5", model_reg[5], 32'h0000000E);

    // Writes to r0 are discarded and never bypassed.
    tick();
    rs_addr = 0; rt_addr = 0;
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hDEADBEEF;
    @(negedge clk);
    chk("r0_bypass", rs_data, 32'h0);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("r0_rs", rs_data, 32'h0);
    chk("r0_rt", rt_data, 32'h0);

    // Same-cycle bypass on both ports, then stored value.
    tick();
    rs_addr = 7; rt_addr = 7;
    wr_en = 1'b1; wr_addr = 7; wr_data = 32'h00000003;
    @(negedge clk);
    chk("bypass_rs", rs_data, 32'h00000003);
    chk("bypass_rt", rt_data, 32'h00000003);
    tick();
    wr_en = 1'b0;
    @(negedge clk);
    chk("stored_r7", rs_data, 32'h00000003);

    // Full dump: exactly 32 valid cycles, idx 0..31, r5 shows 0x0E.
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (dump_valid) begin
        chk("dump1_idx", {27'd0, dump_idx}, cnt);
        if (dump_idx == 5) chk("dump1_r5", dump_data, 32'h0000000E);
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
      tick();
    end
    chk("dump1_len", cnt, 32);
    chk("dump1_busy_after", {31'd0, dump_busy}, 32'h0);

    // Asynchronous reset mid-dump at idx 10.
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (dump_valid && dump_idx == 10) begin found = 1'b1; break; end
    end
    chk("reach_idx10", {31'd0, found}, 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, dump_valid}, 32'h0);
    chk("arst_idx", {27'd0, dump_idx}, 32'h0);
    rs_addr = 5; rt_addr = 31;
    #1;
    chk("arst_rs", rs_data, 32'h0);
    chk("arst_rt", rt_data, 32'h0);
    // Writes and dump requests held across an edge during reset are ignored.
    wr_en = 1'b1; wr_addr = 9; wr_data = 32'h99; dump_start = 1'b1;
    tick();
    wr_en = 1'b0; dump_start = 1'b0; rs_addr = 9;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ignored", rs_data, 32'h0);
    chk("rst_dump_ignored", {31'd0, dump_busy}, 32'h0);

    // First edge after reset release accepts a write.
    tick();
    do_write(9, 32'h00000099);
    @(negedge clk);
    chk("post_rst_wr", rs_data, 32'h00000099);

    // Dump with re-start at idx 4, writes mid-dump, and a same-cycle hit.
    tick();
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    cnt = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (dump_valid) begin
        chk("dump2_idx", {27'd0, dump_idx}, cnt);
        if (dump_idx == 20) chk("dump2_r20", dump_data, 32'h00000055);
        if (dump_idx == 25) chk("dump2_r25_bypass", dump_data, 32'h00000077);
        cnt++;
      end else if (cnt > 0) begin
        break;
      end
      tick();
      dump_start = (cnt == 4);
      wr_en   = (cnt == 12) || (cnt == 25);
      wr_addr = (cnt == 25) ? AW'(25) : AW'(20);
      wr_data = (cnt == 25) ? 32'h77 : 32'h55;
    end
    dump_start = 1'b0; wr_en = 1'b0;
    chk("dump2_len", cnt, 32);
    chk("model_r20", model_reg[20], 32'h00000055);

    tick();
    @(negedge clk);
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
